ksa2_serial_seq: RTL and testbench
==================================

Name: ksa2_serial_seq

Overview:
- Digit-serial adder controller: it sequences one internal 2-bit Kogge-Stone slice (inputs a0/a1/b0/b1/cin, outputs sum0/sum1/cout) over WIDTH/2 cycles to add two WIDTH-bit operands.
- A carry register holds the ripple between slices.
- Valid/ready handshake on both the operand side and the result side.
- Used where a full-width adder is too costly and the 2-bit slice is time-shared.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2 (elaboration error otherwise).
- CW, $clog2(WIDTH/2) (min 1), width of the digit counter; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for the LSB slice.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum, {MSB..LSB}.
- out_cout  output  1  carry-out of the MSB slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_sum=0; out_cout=0; carry register=0; digit counter=0; operand shift registers=0.
- States: IDLE, RUN, DONE. Transitions:
  - IDLE: in_ready=1. On in_valid&in_ready: capture in_a/in_b into shift regs and in_cin into carry; cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle the slice adds bits [1:0] of the shift regs plus carry:
    - sum0/sum1 shift into the result register from the MSB end (2 bits/cycle).
    - Slice cout goes to the carry register.
    - Operand regs shift right by 2.
    - cnt increments.
    - When cnt==WIDTH/2-1, that cycle's cout is loaded into out_cout and the state goes to DONE.
  - DONE: out_valid=1; out_sum/out_cout stable; in_ready=0. On out_ready: go to IDLE with out_valid=0.
- Latency: accept edge to out_valid high is exactly WIDTH/2+1 rising edges (WIDTH=8: 5). Throughput: one add per WIDTH/2+2 cycles when out_ready is held 1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready is a registered/state decode only.
- out_sum and out_cout change only while in RUN. They hold their last value through IDLE until the next result completes. Consumers sample them only while out_valid=1.
- Arithmetic: {out_cout,out_sum} == in_a + in_b + in_cin, modulo 2^(WIDTH+1); no overflow flag.
- in_valid while not in IDLE: ignored (in_ready=0). The requester must hold its operands until the handshake.
- out_ready high in IDLE or RUN: no effect.
- Backpressure: DONE holds indefinitely while out_ready=0.
- WIDTH=2: a single RUN cycle; the counter compare is still used.
- Reset mid-operation (RUN or DONE): all state clears immediately and the partial result is discarded. After release, in_ready=1 on the first cycle.

Test Plan:
- Carry ripple: WIDTH=8, a=0xFF, b=0x01, cin=0 -> out_valid 5 edges after accept; out_sum=0x00, out_cout=1; busy high for exactly 5 cycles.
- Carry-in: a=0x7F, b=0x80, cin=1 -> out_sum=0x00, out_cout=1. Same operands with cin=0 -> 0xFF, cout=0.
- Backpressure: a=0x35, b=0x4A, cin=0, out_ready=0 for 10 cycles -> out_valid and out_sum=0x7F hold stable, in_ready=0 throughout. out_ready=1 -> next cycle IDLE, in_ready=1.
- Back-to-back with out_ready tied 1: three requests (0x12+0x34, 0xAA+0x55 cin=1, 0x00+0x00) -> results 0x46/0, 0x00/1, 0x00/0. Each transaction is 6 cycles apart; in_valid asserted outside IDLE is not consumed.
- Reset in RUN: assert rst after 2 RUN cycles of 0xF0+0x0F -> outputs return to reset values asynchronously. After release, a new request 0x01+0x01 gives 0x02/0 with no stale carry.
- Randomized cross-check: 1000 random a, b, cin with random out_ready stalls -> every result equals a+b+cin against the reference model; no handshake protocol violations.

Source files
------------

// File: rtl/ksa2_serial_seq.sv
// Digit-serial adder: one 2-bit Kogge-Stone slice is reused across WIDTH/2 cycles,
// with a registered carry between digits and valid/ready handshakes on both sides.
module ksa2_serial_seq #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("ksa2_serial_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic g0, p0, g1, p1, g10, p10, c1;
  logic sum0, sum1, slice_cout;
  logic [WIDTH-1:0] sum_next;

  // 2-bit Kogge-Stone slice: one prefix level merges (g1,p1) with (g0,p0)
  always_comb begin
    g0         = a_sr[0] & b_sr[0];
    p0         = a_sr[0] ^ b_sr[0];
    g1         = a_sr[1] & b_sr[1];
    p1         = a_sr[1] ^ b_sr[1];
    g10        = g1 | (p1 & g0);
    p10        = p1 & p0;
    c1         = g0 | (p0 & carry);
    sum0       = p0 ^ carry;
    sum1       = p1 ^ c1;
    slice_cout = g10 | (p10 & carry);
    // New digit enters at the MSB end; after DIGITS shifts digit 0 sits at the LSB
    sum_next   = WIDTH'({sum1, sum0, sum_sr} >> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            carry    <= in_cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_next;
          carry  <= slice_cout;
          a_sr   <= a_sr >> 2;
          b_sr   <= b_sr >> 2;
          cnt    <= cnt + CW'(1);
          // Publish the result only once complete so out_sum stays stable otherwise
          if (cnt == LAST_DIGIT) begin
            out_sum   <= sum_next;
            out_cout  <= slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa2_serial_seq.sv
// Self-checking bench for ksa2_serial_seq (WIDTH=8): directed vector table,
// hand-written handshake/reset sequences and a randomized arithmetic cross-check.
module tb_ksa2_serial_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int checks = 0;
  int failures = 0;

  ksa2_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", 32'(in_ready), 1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result, optionally stalls, then completes the handshake.
  task automatic recv(input int stall, input bit noise, output logic [W-1:0] s,
                      output logic c, output int lat, output int bcnt);
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!out_valid && lat < 60) begin
      check("run_in_ready", 32'(in_ready), 0);
      if (noise) begin
        in_valid  = 1'b1;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_cin    = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("out_valid_seen", 32'(out_valid), 1);
    s = out_sum;
    c = out_cout;
    repeat (stall) begin
      @(negedge clk);
      if (busy) bcnt++;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_sum", 32'(out_sum), 32'(s));
      check("stall_cout", 32'(out_cout), 32'(c));
      check("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (busy) bcnt++;
    check("post_valid", 32'(out_valid), 0);
    check("post_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[8];
    logic [W-1:0] s;
    logic         c;
    int           lat, bc, n;
    logic [W-1:0] ba[3], bb[3], es[3];
    logic         bcin[3], ec[3];
    time          tacc[3];
    logic [W:0]   model;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           stall;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};
    tbl[3] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_cout", 32'(out_cout), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin);
      recv(0, 1'b0, s, c, lat, bc);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(c), 32'(tbl[i].cout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 5);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 5);
    end

    // Backpressure: DONE holds for 10 stalled cycles
    send(8'h35, 8'h4A, 1'b0);
    recv(10, 1'b0, s, c, lat, bc);
    check("bp_sum", 32'(s), 32'h7F);
    check("bp_cout", 32'(c), 0);
    check("bp_busy_cycles", 32'(bc), 15);

    // Back-to-back with out_ready tied high; in_valid stays high with junk outside IDLE
    ba = '{8'h12, 8'hAA, 8'h00}; bb = '{8'h34, 8'h55, 8'h00}; bcin = '{1'b0, 1'b1, 1'b0};
    es = '{8'h46, 8'h00, 8'h00}; ec = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("b2b_in_ready", 32'(in_ready), 1);
      tacc[i] = $time;
      in_a = ba[i]; in_b = bb[i]; in_cin = bcin[i]; in_valid = 1'b1;
      @(negedge clk);
      in_a = 8'hFF; in_b = 8'hFF; in_cin = 1'b1;
      n = 0;
      while (!out_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("b2b%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("b2b%0d_sum", i), 32'(out_sum), 32'(es[i]));
      check($sformatf("b2b%0d_cout", i), 32'(out_cout), 32'(ec[i]));
      if (i == 2) in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle_ready", 32'(in_ready), 1);
    check("b2b_gap01", 32'((tacc[1] - tacc[0]) / 10), 6);
    check("b2b_gap12", 32'((tacc[2] - tacc[1]) / 10), 6);

    // Reset in RUN after a result with nonzero sum and cout
    send(8'h90, 8'h80, 1'b0);
    recv(0, 1'b0, s, c, lat, bc);
    check("pre_rst_sum", 32'(s), 32'h10);
    check("pre_rst_cout", 32'(c), 1);
    send(8'hF0, 8'h0F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_sum", 32'(out_sum), 0);
    check("midrst_out_cout", 32'(out_cout), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", 32'(in_ready), 1);
    send(8'h01, 8'h01, 1'b0);
    recv(0, 1'b0, s, c, lat, bc);
    check("postrst_sum", 32'(s), 32'h02);
    check("postrst_cout", 32'(c), 0);

    // Randomized cross-check against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      model = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
      send(ra, rb, rc);
      recv(stall, 1'($urandom), s, c, lat, bc);
      check("rnd_sum", 32'(s), 32'(model[W-1:0]));
      check("rnd_cout", 32'(c), 32'(model[W]));
      check("rnd_latency", 32'(lat), 5);
      check("rnd_busy_cycles", 32'(bc), 5 + stall);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
